// File: rtl/multiplier.sv
// Sequential radix-2 shift-add multiplier with go/available handshake.
// Returns the low or high WIDTH bits of the signed or unsigned 2*WIDTH product.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             go,
  input  logic             muls,
  input  logic             high,
  output logic [WIDTH-1:0] c,
  output logic             is_zero,
  output logic             is_negative,
  output logic             available
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  // Upper half accumulates partial sums; lower half holds the shifting multiplier.
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_high;
  logic [WIDTH-1:0]   r_c;
  logic               r_zero;
  logic               r_negf;
  logic               r_avail;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_accept;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_abs_a  = (muls && a[WIDTH-1]) ? -a : a;
    w_abs_b  = (muls && b[WIDTH-1]) ? -b : b;
    w_addend = r_acc[0] ? {1'b0, r_mcand} : '0;
    // One extra bit keeps the carry out of the upper half (all-ones operands).
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    w_prod   = r_neg ? -r_acc : r_acc;
    w_res    = r_high ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
    w_accept = go && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_high  <= 1'b0;
      r_c     <= '0;
      r_zero  <= 1'b0;
      r_negf  <= 1'b0;
      r_avail <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_c     <= w_res;
          r_zero  <= (w_res == '0);
          r_negf  <= w_res[WIDTH-1];
          r_avail <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          if (w_accept) begin
            r_mcand <= w_abs_a;
            r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
            r_neg   <= muls & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_high  <= high;
            r_cnt   <= CW'(WIDTH);
            r_avail <= 1'b0;
            r_state <= S_RUN;
          end
        end
      endcase
    end
  end

  assign c           = r_c;
  assign is_zero     = r_zero;
  assign is_negative = r_negf;
  assign available   = r_avail;

endmodule
